// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch front end.
// Queue entries are sized by PKG_ADDR_WIDTH/PKG_DATA_WIDTH; fetch_unit's width parameters default to these.
package parameter_pkg;

  localparam int INST_BYTES     = 4;
  localparam int PKG_ADDR_WIDTH = 32;
  localparam int PKG_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    IDLE  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PKG_ADDR_WIDTH-1:0] pc;
    logic [PKG_DATA_WIDTH-1:0] inst;
    logic                      pred_taken;
  } fq_entry_t;

endpackage

// File: rtl/fetch_unit_fetch_queue.sv
// Two-in / two-out circular FIFO of fetched instructions with a single-cycle flush.
// Callers must never push more than the free space or pop more than the occupancy.
module fetch_queue
  import parameter_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic [1:0]      i_push_n,
  input  fq_entry_t       i_push_0,
  input  fq_entry_t       i_push_1,
  input  logic [1:0]      i_pop_n,
  output fq_entry_t       o_head_0,
  output fq_entry_t       o_head_1,
  output logic [CW-1:0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     w_head_1;
  logic [PW-1:0]     w_tail_1;

  assign w_head_1 = r_head + PW'(1);
  assign w_tail_1 = r_tail + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(i_pop_n);
      r_tail  <= r_tail + PW'(i_push_n);
      r_count <= r_count + CW'(i_push_n) - CW'(i_pop_n);
    end
  end

  // NOTE: storage has no reset; the pointers and count define which entries are live, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (!i_flush) begin
      if (i_push_n != 2'd0) r_mem[r_tail]   <= i_push_0;
      if (i_push_n == 2'd2) r_mem[w_tail_1] <= i_push_1;
    end
  end

  assign o_head_0 = r_mem[r_head];
  assign o_head_1 = r_mem[w_head_1];
  assign o_count  = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC selection and FETCH/STALL/IDLE control feeding a
// 2-wide fetch queue; decode outputs come only from registered queue state.
module fetch_unit
  import parameter_pkg::*;
#(
  parameter int                    ADDR_WIDTH = PKG_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int                    FQ_DEPTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [ADDR_WIDTH-1:0]     rom_addr,
  output logic                      rom_predict_taken,
  input  logic [DATA_WIDTH-1:0]     rom_inst_0,
  input  logic [DATA_WIDTH-1:0]     rom_inst_1,
  input  logic [1:0]                rom_valid,
  input  logic                      bp_taken,
  input  logic [ADDR_WIDTH-1:0]     bp_target,
  input  logic                      redirect_valid,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic [1:0]                dec_valid,
  output logic [DATA_WIDTH-1:0]     dec_inst_0,
  output logic [DATA_WIDTH-1:0]     dec_inst_1,
  output logic [ADDR_WIDTH-1:0]     dec_pc_0,
  output logic [ADDR_WIDTH-1:0]     dec_pc_1,
  output logic [1:0]                dec_pred_taken,
  input  logic                      dec_ready,
  output logic [$clog2(FQ_DEPTH):0] fq_count,
  output logic [1:0]                fetch_state
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_t          r_state;
  fetch_state_t          w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_free;
  logic [CW-1:0]         w_free_after;
  logic                  w_fetch_en;
  logic [1:0]            w_n_push;
  logic [1:0]            w_n_pop;
  logic [1:0]            w_dec_valid;
  fq_entry_t             w_push_0;
  fq_entry_t             w_push_1;
  fq_entry_t             w_head_0;
  fq_entry_t             w_head_1;
  logic                  w_unused;

  // Free space is taken from the registered count; pops this cycle are not credited.
  assign w_free       = CW'(FQ_DEPTH) - w_count;
  assign w_dec_valid  = {w_count >= CW'(2), w_count >= CW'(1)};
  assign w_n_pop      = dec_ready ? (w_dec_valid[1] ? 2'd2 : {1'b0, w_dec_valid[0]}) : 2'd0;
  assign w_free_after = w_free - CW'(w_n_push) + CW'(w_n_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  // NOTE: each combinational block assigns a default first so no path leaves a latch behind.
  always_comb begin
    w_next_state = r_state;
    if (redirect_valid) begin
      w_next_state = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_free_after < CW'(2))               w_next_state = STALL;
          else if (w_fetch_en && w_n_push == 2'd0) w_next_state = IDLE;
        end
        STALL:   if (w_free >= CW'(2)) w_next_state = FETCH;
        IDLE:    w_next_state = IDLE;
        default: w_next_state = FETCH;
      endcase
    end
  end

  // Fetching is only done in FETCH; IDLE keeps the PC parked until a redirect arrives.
  always_comb begin
    w_fetch_en = (r_state == FETCH) && (w_free >= CW'(2)) && !redirect_valid;
    w_n_push   = 2'd0;
    if (w_fetch_en) begin
      if (rom_valid == 2'b11) w_n_push = 2'd2;
      else if (rom_valid[0])  w_n_push = 2'd1;
    end
  end

  always_comb begin
    w_next_pc = r_pc + ADDR_WIDTH'(w_n_push) * ADDR_WIDTH'(INST_BYTES);
    if (redirect_valid)                     w_next_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    else if (w_n_push != 2'd0 && bp_taken)  w_next_pc = {bp_target[ADDR_WIDTH-1:2], 2'b00};
  end

  assign w_push_0 = '{pc: r_pc, inst: rom_inst_0, pred_taken: bp_taken};
  assign w_push_1 = '{pc: r_pc + ADDR_WIDTH'(INST_BYTES), inst: rom_inst_1, pred_taken: 1'b0};

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_flush  (redirect_valid),
    .i_push_n (w_n_push),
    .i_push_0 (w_push_0),
    .i_push_1 (w_push_1),
    .i_pop_n  (w_n_pop),
    .o_head_0 (w_head_0),
    .o_head_1 (w_head_1),
    .o_count  (w_count)
  );

  assign rom_addr          = r_pc;
  assign rom_predict_taken = bp_taken;
  assign dec_valid         = w_dec_valid;
  assign dec_inst_0        = w_dec_valid[0] ? w_head_0.inst : '0;
  assign dec_inst_1        = w_dec_valid[1] ? w_head_1.inst : '0;
  assign dec_pc_0          = w_dec_valid[0] ? w_head_0.pc   : '0;
  assign dec_pc_1          = w_dec_valid[1] ? w_head_1.pc   : '0;
  assign dec_pred_taken    = w_dec_valid & {w_head_1.pred_taken, w_head_0.pred_taken};
  assign fq_count          = w_count;
  assign fetch_state       = r_state;

  // Low address bits of redirect and branch targets are always forced to word alignment.
  assign w_unused = ^{bp_target[1:0], redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the fetch/decode rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic        rom_predict_taken;
  logic [31:0] rom_inst_0, rom_inst_1;
  logic [1:0]  rom_valid;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  dec_valid;
  logic [31:0] dec_inst_0, dec_inst_1, dec_pc_0, dec_pc_1;
  logic [1:0]  dec_pred_taken;
  logic        dec_ready;
  logic [3:0]  fq_count;
  logic [1:0]  fetch_state;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rom_addr          (rom_addr),
    .rom_predict_taken (rom_predict_taken),
    .rom_inst_0        (rom_inst_0),
    .rom_inst_1        (rom_inst_1),
    .rom_valid         (rom_valid),
    .bp_taken          (bp_taken),
    .bp_target         (bp_target),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .dec_valid         (dec_valid),
    .dec_inst_0        (dec_inst_0),
    .dec_inst_1        (dec_inst_1),
    .dec_pc_0          (dec_pc_0),
    .dec_pc_1          (dec_pc_1),
    .dec_pred_taken    (dec_pred_taken),
    .dec_ready         (dec_ready),
    .fq_count          (fq_count),
    .fetch_state       (fetch_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: program counter, control mode (0 fetch, 1 stall, 2 idle) and the queue itself.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pt;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  int          m_state;
  logic [31:0] seen[$];

  // ROM / predictor environment knobs.
  logic [31:0] prog_end = 32'h0;
  logic [31:0] bp_pc    = 32'h0;
  logic [31:0] bp_tgt   = 32'h0;
  bit          bp_en    = 1'b0;
  bit          rnd_mode = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  task automatic drive_rom();
    rom_inst_0 = inst_of(m_pc);
    rom_inst_1 = inst_of(m_pc + 32'd4);
    rom_valid  = {(m_pc + 32'd4) < prog_end, m_pc < prog_end};
    bp_taken   = 1'b0;
    bp_target  = 32'h0;
    if (bp_en && m_pc == bp_pc && m_pc < prog_end) begin
      bp_taken  = 1'b1;
      bp_target = bp_tgt;
      rom_valid = 2'b01;
    end
    if (rnd_mode) begin
      if (m_pc < prog_end && $urandom_range(0, 7) == 0) begin
        bp_taken  = 1'b1;
        bp_target = 32'($urandom_range(0, 511));
        rom_valid = 2'b01;
      end else if ($urandom_range(0, 15) == 0) begin
        rom_valid = 2'b10;
      end
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = 32'h0;
    m_state = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied to the DUT.
  task automatic model_step();
    int  cnt, free, np, npop;
    bit  fen;
    cnt  = m_q.size();
    free = 8 - cnt;
    fen  = (m_state == 0) && (free >= 2) && !redirect_valid;
    np   = 0;
    if (fen) np = (rom_valid == 2'b11) ? 2 : (rom_valid[0] ? 1 : 0);
    npop = dec_ready ? ((cnt >= 2) ? 2 : cnt) : 0;
    if (redirect_valid) begin
      m_q.delete();
      m_pc    = redirect_pc & ~32'h3;
      m_state = 0;
    end else begin
      repeat (npop) void'(m_q.pop_front());
      if (np >= 1) m_q.push_back('{m_pc, rom_inst_0, bp_taken});
      if (np == 2) m_q.push_back('{m_pc + 32'd4, rom_inst_1, 1'b0});
      if (m_state == 0) begin
        if (8 - m_q.size() < 2)     m_state = 1;
        else if (fen && np == 0)    m_state = 2;
      end else if (m_state == 1) begin
        if (free >= 2) m_state = 0;
      end
      if (np >= 1 && bp_taken) m_pc = bp_target & ~32'h3;
      else                     m_pc = m_pc + 32'(4 * np);
    end
  endtask

  task automatic compare_model();
    logic [1:0] ev;
    ev = {m_q.size() >= 2, m_q.size() >= 1};
    checks++;
    if (rom_addr !== m_pc) begin
      errors++; $display("FAIL rom_addr act=%h exp=%h t=%0t", rom_addr, m_pc, $time);
    end
    checks++;
    if (rom_predict_taken !== bp_taken) begin
      errors++; $display("FAIL rom_predict_taken act=%b exp=%b t=%0t", rom_predict_taken, bp_taken, $time);
    end
    checks++;
    if (fq_count !== 4'(m_q.size())) begin
      errors++; $display("FAIL fq_count act=%0d exp=%0d t=%0t", fq_count, m_q.size(), $time);
    end
    checks++;
    if (fetch_state !== 2'(m_state)) begin
      errors++; $display("FAIL fetch_state act=%0d exp=%0d t=%0t", fetch_state, m_state, $time);
    end
    checks++;
    if (dec_valid !== ev) begin
      errors++; $display("FAIL dec_valid act=%b exp=%b t=%0t", dec_valid, ev, $time);
    end
    if (m_q.size() >= 1) begin
      checks++;
      if ({dec_pc_0, dec_inst_0, dec_pred_taken[0]} !== {m_q[0].pc, m_q[0].inst, m_q[0].pt}) begin
        errors++; $display("FAIL slot0 act=%h/%h/%b exp=%h/%h/%b t=%0t", dec_pc_0, dec_inst_0,
                           dec_pred_taken[0], m_q[0].pc, m_q[0].inst, m_q[0].pt, $time);
      end
    end
    if (m_q.size() >= 2) begin
      checks++;
      if ({dec_pc_1, dec_inst_1, dec_pred_taken[1]} !== {m_q[1].pc, m_q[1].inst, m_q[1].pt}) begin
        errors++; $display("FAIL slot1 act=%h/%h/%b exp=%h/%h/%b t=%0t", dec_pc_1, dec_inst_1,
                           dec_pred_taken[1], m_q[1].pc, m_q[1].inst, m_q[1].pt, $time);
      end
    end
  endtask

  // One clock: inputs applied just after the rising edge, outputs sampled on the falling edge.
  task automatic cycle();
    drive_rom();
    @(negedge clk);
    compare_model();
    if (dec_ready && dec_valid[0]) seen.push_back(dec_pc_0);
    if (dec_ready && dec_valid[1]) seen.push_back(dec_pc_1);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;
    model_reset();
    drive_rom();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;
    model_reset();
    drive_rom();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr act=%h exp=0", rom_addr); end
    checks++;
    if (fq_count !== 4'd0) begin errors++; $display("FAIL reset_fq_count act=%0d exp=0", fq_count); end
    checks++;
    if (dec_valid !== 2'b00) begin errors++; $display("FAIL reset_dec_valid act=%b exp=00", dec_valid); end
    checks++;
    if (fetch_state !== 2'd0) begin errors++; $display("FAIL reset_state act=%0d exp=0", fetch_state); end
    checks++;
    if ({dec_inst_0, dec_inst_1, dec_pc_0, dec_pc_1, dec_pred_taken} !== '0) begin
      errors++; $display("FAIL reset_dec_data act=%h/%h/%h/%h/%b exp=0", dec_inst_0, dec_inst_1,
                         dec_pc_0, dec_pc_1, dec_pred_taken);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    apply_reset();
    prog_end  = 32'h18;
    dec_ready = 1'b1;
    seen.delete();
    repeat (6) cycle();
    checks++;
    if (fetch_state !== 2'd2) begin errors++; $display("FAIL seq_idle act=%0d exp=2", fetch_state); end
    checks++;
    if (rom_addr !== 32'h18) begin errors++; $display("FAIL seq_pc_held act=%h exp=18", rom_addr); end
    checks++;
    if (seen.size() != 6) begin errors++; $display("FAIL seq_count act=%0d exp=6", seen.size()); end
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== 32'(4 * i)) begin
        errors++; $display("FAIL seq_order[%0d] act=%h exp=%h", i, seen[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    prog_end  = 32'h400;
    dec_ready = 1'b0;
    repeat (5) cycle();
    checks++;
    if (fq_count !== 4'd8) begin errors++; $display("FAIL stall_full act=%0d exp=8", fq_count); end
    checks++;
    if (fetch_state !== 2'd1) begin errors++; $display("FAIL stall_state act=%0d exp=1", fetch_state); end
    checks++;
    if (rom_addr !== 32'h20) begin errors++; $display("FAIL stall_pc act=%h exp=20", rom_addr); end
    dec_ready = 1'b1;
    cycle();
    checks++;
    if (fq_count !== 4'd6) begin errors++; $display("FAIL stall_pop2 act=%0d exp=6", fq_count); end
    cycle();
    checks++;
    if (fq_count !== 4'd4 || fetch_state !== 2'd0) begin
      errors++; $display("FAIL stall_resume act=%0d/%0d exp=4/0", fq_count, fetch_state);
    end
    repeat (4) cycle();
  endtask

  task automatic test_branch();
    apply_reset();
    prog_end  = 32'h400;
    bp_en     = 1'b1;
    bp_pc     = 32'h8;
    bp_tgt    = 32'h40;
    dec_ready = 1'b1;
    repeat (2) cycle();
    checks++;
    if ({dec_valid, dec_pc_0, dec_pred_taken} !== {2'b01, 32'h8, 2'b01}) begin
      errors++; $display("FAIL branch_push act=%b/%h/%b exp=01/00000008/01", dec_valid, dec_pc_0, dec_pred_taken);
    end
    checks++;
    if (rom_addr !== 32'h40) begin errors++; $display("FAIL branch_target act=%h exp=40", rom_addr); end
    repeat (3) cycle();
    bp_en = 1'b0;
  endtask

  task automatic test_redirect();
    apply_reset();
    prog_end  = 32'h14;
    dec_ready = 1'b0;
    repeat (3) cycle();
    checks++;
    if (fq_count !== 4'd5) begin errors++; $display("FAIL redir_fill act=%0d exp=5", fq_count); end
    prog_end       = 32'h400;
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if ({fq_count, dec_valid, rom_addr} !== {4'd0, 2'b00, 32'h100}) begin
      errors++; $display("FAIL redir_flush act=%0d/%b/%h exp=0/00/00000100", fq_count, dec_valid, rom_addr);
    end
    cycle();
    checks++;
    if ({dec_valid, dec_pc_0} !== {2'b11, 32'h100}) begin
      errors++; $display("FAIL redir_restart act=%b/%h exp=11/00000100", dec_valid, dec_pc_0);
    end
    repeat (3) cycle();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    prog_end  = 32'h1000;
    dec_ready = 1'b0;
    repeat (3) cycle();
    dec_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (fq_count !== 4'd6) begin errors++; $display("FAIL b2b_count[%0d] act=%0d exp=6", i, fq_count); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    prog_end  = 32'h400;
    dec_ready = 1'b0;
    repeat (5) cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rom_addr, fq_count, dec_valid, fetch_state, dec_pc_0} !== {32'h0, 4'd0, 2'b00, 2'd0, 32'h0}) begin
      errors++; $display("FAIL async_reset act=%h/%0d/%b/%0d/%h exp=0", rom_addr, fq_count, dec_valid,
                         fetch_state, dec_pc_0);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    dec_ready = 1'b1;
    repeat (4) cycle();
  endtask

  task automatic test_random();
    apply_reset();
    prog_end = 32'h180;
    rnd_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 32'($urandom_range(0, 511));
      cycle();
    end
    redirect_valid = 1'b0;
    rnd_mode       = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_redirect();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
